pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the 5-stage CPU, replacing the fixed 32-bit stage register.
- Carries a data word plus a valid bit.
- Supports enable (stall), synchronous flush (bubble insertion), and a multi-cycle hold window for iterative units such as multiply/divide.
- The hold length is a per-operation count or a parameter default.

Parameters:
- WIDTH, 32: data path width in bits.
- CNT_W, 6: width of the hold counter and of mc_len.
- MC_DEFAULT, 32: hold length used when mc_len = 0; legal range 1..2^CNT_W-1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  load enable; 0 = stall (hold contents).
- flush  in  1  synchronous bubble insert / multi-cycle abort.
- d_in  in  WIDTH  data to capture.
- valid_in  in  1  valid bit accompanying d_in.
- mc_start  in  1  begin multi-cycle hold (sampled in IDLE only).
- mc_len  in  CNT_W  hold length in cycles; 0 selects MC_DEFAULT.
- d_out  out  WIDTH  registered data.
- valid_out  out  1  registered valid.
- mc_busy  out  1  high while hold window active.
- mc_done  out  1  one-cycle pulse after the hold completes normally.

Behaviour:
- Reset (rst = 1 at edge): d_out = 0, valid_out = 0, mc_busy = 0, mc_done = 0, counter = 0, state = IDLE.
- Priority at each edge: rst > flush > BUSY hold > normal load.
- States: IDLE, BUSY. mc_busy = (state == BUSY), driven from a register, not decoded combinationally from inputs.
- IDLE:
  - en = 1: d_out <= d_in, valid_out <= valid_in.
  - en = 0: hold d_out and valid_out.
- IDLE, mc_start = 1 at edge E0:
  - Load per en as above.
  - state <= BUSY; counter <= L-1, where L = mc_len, or MC_DEFAULT if mc_len = 0.
- BUSY:
  - d_out and valid_out hold regardless of en and d_in.
  - counter decrements each edge.
  - At the edge where counter == 0: state <= IDLE, mc_done <= 1.
  - mc_busy is therefore high for exactly L cycles following E0.
  - At that final edge the register does not load; loading resumes at the next edge.
- mc_done: high for exactly one cycle, then 0. It is never asserted by reset or by abort.
- mc_start while BUSY: ignored; no restart, no counter reload.
- flush = 1 (not rst):
  - valid_out <= 0, d_out <= 0, mc_done <= 0.
  - If BUSY: abort; state <= IDLE, counter <= 0.
  - mc_start in the same cycle is ignored.
- flush with en = 0: flush still wins; a bubble is inserted.
- Counter arithmetic is unsigned CNT_W-bit and never wraps: BUSY exits at 0.
- L = 1: mc_busy high for one cycle; mc_done follows in the next cycle.
- rst mid-BUSY: immediate return to IDLE; all outputs 0 next cycle.

Optional Feature:
- Macro PIPE_STAGE_REG_STALL_CNT_EN.
- When defined: adds output stall_cnt [31:0].
  - Reset to 0.
  - Increments by 1 at each edge where rst = 0 and (mc_busy = 1 or en = 0).
  - Saturates at 32'hFFFF_FFFF.
  - Flush does not clear it.
- When not defined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset/load: rst 1 cycle, then en = 1, d_in = 32'hDEAD_BEEF, valid_in = 1 → next cycle d_out = 32'hDEAD_BEEF, valid_out = 1; with en = 0 and d_in = 32'h1234 the outputs hold.
- Default hold: mc_start = 1 with mc_len = 0, en = 1, d_in = 32'hA5 → d_out = 32'hA5. Then mc_busy is high for exactly 32 cycles while d_in toggles and en = 1, and d_out stays 32'hA5. mc_done is high for exactly 1 cycle after mc_busy falls, and the next en = 1 loads new data.
- Short hold: mc_len = 1 → mc_busy for 1 cycle, then mc_done for 1 cycle. mc_len = 5 → mc_busy for 5 cycles; a mc_start pulse at busy cycle 2 is ignored (still 5 cycles total).
- Abort: mc_len = 10, flush at busy cycle 4 → next cycle mc_busy = 0, valid_out = 0, d_out = 0, and mc_done never pulses.
- Reset mid-op: rst at busy cycle 7 of 32 → all outputs 0 next cycle; a new mc_start afterwards produces a full 32-cycle window.
- Stall counter (with PIPE_STAGE_REG_STALL_CNT_EN): 3 cycles en = 0, then a hold with mc_len = 4 → stall_cnt = 7. A build without the macro compiles without stall_cnt.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with stall, flush and multi-cycle hold window.
// Optional PIPE_STAGE_REG_STALL_CNT_EN adds a saturating stall_cnt output.
module pipe_stage_reg #(
  parameter int WIDTH      = 32,
  parameter int CNT_W      = 6,
  parameter int MC_DEFAULT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_in,
  input  logic             valid_in,
  input  logic             mc_start,
  input  logic [CNT_W-1:0] mc_len,
  output logic [WIDTH-1:0] d_out,
  output logic             valid_out,
  output logic             mc_busy,
  output logic             mc_done
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len;
  logic [WIDTH-1:0] d_q, d_d;
  logic v_q, v_d, done_q, done_d, busy, last, load, start;
  assign busy  = state_q == BUSY;
  assign last  = busy && cnt_q == '0;
  assign load  = !flush && !busy && en;
  assign start = !flush && !busy && mc_start;
  assign len   = mc_len == '0 ? CNT_W'(MC_DEFAULT) : mc_len;
  always_comb begin
    d_d     = flush ? '0 : load ? d_in : d_q;
    v_d     = flush ? 1'b0 : load ? valid_in : v_q;
    done_d  = !flush && last;
    state_d = start ? BUSY : (flush || last) ? IDLE : state_q;
    cnt_d   = start ? len - CNT_W'(1) : flush ? '0 : (busy && !last) ? cnt_q - CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end
  assign d_out     = d_q;
  assign valid_out = v_q;
  assign mc_busy   = busy;
  assign mc_done   = done_q;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else if ((busy || !en) && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scoreboard bench for pipe_stage_reg (default build or PIPE_STAGE_REG_STALL_CNT_EN).
module tb_pipe_stage_reg;
  logic clk = 1'b0, rst, en, flush, valid_in, mc_start;
  logic [31:0] d_in, d_out;
  logic [5:0] mc_len;
  logic valid_out, mc_busy, mc_done;
  int errors = 0, checks = 0;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  typedef struct {logic [31:0] d; logic v, b, dn; string tag;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d_in(d_in), .valid_in(valid_in),
    .mc_start(mc_start), .mc_len(mc_len), .d_out(d_out), .valid_out(valid_out),
    .mc_busy(mc_busy), .mc_done(mc_done)
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  task automatic cyc(input logic r, e, f, input logic [31:0] din, input logic vin, ms,
                     input logic [5:0] len, input logic [31:0] ed, input logic ev, eb, edn,
                     input string tag);
    exp_t x;
    rst = r; en = e; flush = f; d_in = din; valid_in = vin; mc_start = ms; mc_len = len;
    sb.push_back('{ed, ev, eb, edn, tag});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".d_out"}, d_out, x.d);
    chk({x.tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, x.v});
    chk({x.tag, ".mc_busy"}, {31'd0, mc_busy}, {31'd0, x.b});
    chk({x.tag, ".mc_done"}, {31'd0, mc_done}, {31'd0, x.dn});
  endtask
  initial begin
    rst = 1; en = 0; flush = 0; d_in = 0; valid_in = 0; mc_start = 0; mc_len = 0;
    cyc(1, 1, 0, 32'hFFFF, 1, 1, 0, 0, 0, 0, 0, "reset");
    cyc(0, 1, 0, 32'hDEAD_BEEF, 1, 0, 0, 32'hDEAD_BEEF, 1, 0, 0, "load");
    cyc(0, 0, 0, 32'h1234, 0, 0, 0, 32'hDEAD_BEEF, 1, 0, 0, "stall_hold");
    // default hold: 32 busy cycles, data frozen while d_in toggles
    cyc(0, 1, 0, 32'hA5, 1, 1, 0, 32'hA5, 1, 1, 0, "def_start");
    for (int i = 1; i < 32; i++)
      cyc(0, 1, 0, (i % 2) ? 32'h5A5A_0000 + i : ~32'(i), i % 2 == 0, 0, 0, 32'hA5, 1, 1, 0, "def_busy");
    cyc(0, 1, 0, 32'hCAFE, 0, 0, 0, 32'hA5, 1, 0, 1, "def_done");
    cyc(0, 1, 0, 32'h55, 1, 0, 0, 32'h55, 1, 0, 0, "def_resume");
    // L = 1
    cyc(0, 1, 0, 32'h11, 1, 1, 1, 32'h11, 1, 1, 0, "l1_start");
    cyc(0, 1, 0, 32'h22, 1, 0, 0, 32'h11, 1, 0, 1, "l1_done");
    cyc(0, 1, 0, 32'h33, 1, 0, 0, 32'h33, 1, 0, 0, "l1_resume");
    // L = 5 with an ignored restart in busy cycle 2
    cyc(0, 1, 0, 32'h44, 1, 1, 5, 32'h44, 1, 1, 0, "l5_start");
    for (int i = 1; i < 5; i++)
      cyc(0, 1, 0, 32'h40 + i, 1, i == 2, 3, 32'h44, 1, 1, 0, "l5_busy");
    cyc(0, 1, 0, 32'h49, 1, 0, 0, 32'h44, 1, 0, 1, "l5_done");
    cyc(0, 0, 0, 32'h4A, 1, 0, 0, 32'h44, 1, 0, 0, "l5_after");
    // abort L = 10 at busy cycle 4; no done pulse afterwards
    cyc(0, 1, 0, 32'h66, 1, 1, 10, 32'h66, 1, 1, 0, "ab_start");
    for (int i = 1; i < 4; i++)
      cyc(0, 1, 0, 32'h60, 1, 0, 0, 32'h66, 1, 1, 0, "ab_busy");
    cyc(0, 1, 1, 32'h60, 1, 0, 0, 0, 0, 0, 0, "ab_flush");
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 0, 32'h61, 1, 0, 0, 0, 0, 0, 0, "ab_after");
    // flush beats en=0 and mc_start
    cyc(0, 1, 0, 32'h77, 1, 0, 0, 32'h77, 1, 0, 0, "fl_load");
    cyc(0, 0, 1, 32'h78, 1, 1, 2, 0, 0, 0, 0, "fl_bubble");
    cyc(0, 0, 0, 32'h79, 1, 0, 0, 0, 0, 0, 0, "fl_nostart");
    // reset at busy cycle 7, then a full fresh window
    cyc(0, 1, 0, 32'h88, 1, 1, 0, 32'h88, 1, 1, 0, "rs_start");
    for (int i = 1; i < 7; i++)
      cyc(0, 1, 0, 32'h80, 1, 0, 0, 32'h88, 1, 1, 0, "rs_busy");
    cyc(1, 1, 0, 32'h80, 1, 1, 0, 0, 0, 0, 0, "rs_reset");
    cyc(0, 1, 0, 32'h99, 1, 1, 0, 32'h99, 1, 1, 0, "rs_restart");
    for (int i = 1; i < 32; i++)
      cyc(0, 0, 0, 32'h90, 0, 0, 0, 32'h99, 1, 1, 0, "rs_busy2");
    cyc(0, 0, 0, 32'h90, 0, 0, 0, 32'h99, 1, 0, 1, "rs_done");
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "sc_reset");
    chk("sc_zero", stall_cnt, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 32'h1, 1, 0, 0, 0, 0, 0, 0, "sc_stall");
    chk("sc_three", stall_cnt, 3);
    cyc(0, 1, 0, 32'h2, 1, 1, 4, 32'h2, 1, 1, 0, "sc_start");
    for (int i = 1; i < 4; i++)
      cyc(0, 1, 0, 32'h3, 1, 0, 0, 32'h2, 1, 1, 0, "sc_busy");
    cyc(0, 1, 0, 32'h3, 1, 0, 0, 32'h2, 1, 0, 1, "sc_done");
    chk("sc_seven", stall_cnt, 7);
    cyc(0, 1, 1, 32'h4, 1, 0, 0, 0, 0, 0, 0, "sc_flush");
    chk("sc_keep", stall_cnt, 7);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
